sn_net_ctrlr_mc: RTL and testbench
==================================

SN_NET_CTRLR_MC -- requirements
Module: sn_net_ctrlr_mc

Interface
REQ-001 SHALL have parameter P_MAX_NUM_PERIODS, default 100, max configurable execution periods.
REQ-002 SHALL have parameter P_MAX_WARMUP, default 255, max configurable warmup evaluations.
REQ-003 SHALL have parameter P_NUM_CH, default 4, number of independent transmit (API) channels.
REQ-004 SHALL define PW=$clog2(P_MAX_NUM_PERIODS+1) and WW=$clog2(P_MAX_WARMUP+1).
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 io_nc_start  in  1  software start pulse.
REQ-008 io_nc_abort  in  1  software abort request.
REQ-009 io_nc_max_per  in  PW  number of periods to execute.
REQ-010 io_nc_warmup_cnt  in  WW  number of warmup evaluations before period 1.
REQ-011 io_nc_ch_en  in  P_NUM_CH  per-channel transmit enable.
REQ-012 io_nc_final_tx  in  1  1 = run a transmit phase after the final evaluation.
REQ-013 api_nc_done  in  P_NUM_CH  per-channel transmit-complete.
REQ-014 nc_reset  out  1  neuron reset, combinational on start acceptance.
REQ-015 nc_warmup  out  1  high during warmup.
REQ-016 nc_evaluate  out  1  neuron evaluate strobe.
REQ-017 nc_transmit  out  P_NUM_CH  per-channel transmit request.
REQ-018 nc_io_cur_per  out  PW  current period number.
REQ-019 nc_io_busy  out  1  execution in progress.
REQ-020 nc_io_done  out  1  idle and ready.
REQ-021 nc_io_aborted  out  1  last execution ended by abort.

Function
REQ-022 SHALL implement FSM states IDLE, WARMUP, EVAL, TRANS.
REQ-023 Start accepted only in IDLE with io_nc_max_per!=0; otherwise ignored (no nc_reset, no state change).
REQ-024 On acceptance: nc_reset=1 same cycle; max_per, warmup_cnt, ch_en, final_tx latched into shadow registers; later input changes ignored until the next acceptance.
REQ-025 io_nc_max_per above P_MAX_NUM_PERIODS SHALL saturate to P_MAX_NUM_PERIODS when latched.
REQ-026 Acceptance: warmup_cnt==0 -> EVAL, cur_per<=1; else -> WARMUP, warmup counter<=warmup_cnt, cur_per<=0.
REQ-027 WARMUP: nc_warmup=1, nc_evaluate=1 every cycle; counter decrements; counter==1 -> EVAL, cur_per<=1; exactly warmup_cnt warmup cycles.
REQ-028 EVAL: nc_evaluate=1 for exactly one cycle; next TRANS unless cur_per==max_per and final_tx==0, then IDLE.
REQ-029 TRANS: nc_transmit[i]=ch_en[i] & ~sent[i]; sent[i] sticky, set on api_nc_done[i] in TRANS, cleared on TRANS exit.
REQ-030 TRANS exits the cycle all enabled channels are satisfied (sent | api_nc_done, masked by ch_en); if cur_per==max_per -> IDLE, else -> EVAL with cur_per<=cur_per+1.
REQ-031 ch_en==0: TRANS lasts exactly one cycle, no nc_transmit asserted.
REQ-032 api_nc_done on disabled channels, or outside TRANS, SHALL be ignored.
REQ-033 nc_transmit[i] SHALL deassert the cycle after api_nc_done[i] is sampled; channels complete in any order.
REQ-034 io_nc_abort in WARMUP/EVAL/TRANS: next state IDLE, nc_io_aborted<=1, all strobes low next cycle, cur_per holds; abort has priority over all other transitions.
REQ-035 io_nc_abort in IDLE ignored; simultaneous start+abort in IDLE SHALL accept the start.
REQ-036 nc_io_aborted cleared on next start acceptance.
REQ-037 nc_io_busy=(state!=IDLE); nc_io_done=(state==IDLE); io_nc_start while busy ignored.
REQ-038 nc_io_cur_per holds its last value in IDLE until next acceptance.

Reset
REQ-039 rst_n low SHALL asynchronously force: state IDLE, cur_per 0, counters 0, sent 0, shadow registers 0, nc_io_done 1, nc_io_aborted 0, all other outputs 0.
REQ-040 Reset assertion mid-execution SHALL drop all strobes immediately, without completing the period.

Verification
REQ-041 warmup_cnt=3, max_per=2, ch_en=4'b0001, final_tx=0, done returned 2 cycles after transmit -> 3 warmup cycles, evaluate per1, transmit, evaluate per2, IDLE; cur_per ends 2.
REQ-042 max_per=1, final_tx=1, ch_en=4'b1011, done on ch3, ch0, ch1 in separate cycles -> each transmit drops individually; TRANS exits after ch1; cur_per=1.
REQ-043 Abort during TRANS of period 5 -> IDLE next cycle, aborted=1, cur_per=5; next start clears aborted, cur_per=0 or 1.
REQ-044 Start with max_per=0, and start while busy -> no nc_reset, no state change.
REQ-045 ch_en=0, max_per=3, warmup_cnt=0 -> E,T,E,T,E strobe pattern, one cycle each, no nc_transmit.
REQ-046 rst_n low mid-EVAL, and max_per=P_MAX_NUM_PERIODS+5 -> immediate reset values; saturated run ends at cur_per=P_MAX_NUM_PERIODS.

Source files
------------

// File: rtl/sn_net_ctrlr_mc_if.sv
// sn_net_ctrlr_mc_if -- control and channel handshake bundle for the network controller.
//
// Signals:
//   io_nc_start       software start pulse
//   io_nc_abort       software abort request
//   io_nc_max_per     number of execution periods to run (PW bits)
//   io_nc_warmup_cnt  number of warmup evaluations before period 1 (WW bits)
//   io_nc_ch_en       per-channel transmit enable
//   io_nc_final_tx    run a transmit phase after the final evaluation
//   api_nc_done       per-channel transmit-complete from the API channels
//   nc_reset          neuron reset, asserted in the cycle a start is accepted
//   nc_warmup         high during warmup evaluations
//   nc_evaluate       neuron evaluate strobe
//   nc_transmit       per-channel transmit request
//   nc_io_cur_per     current period number
//   nc_io_busy        execution in progress
//   nc_io_done        idle and ready
//   nc_io_aborted     last execution ended by abort
//
// Modports: master = software/API side, slave = controller.
`timescale 1ns / 1ps

interface sn_net_ctrlr_mc_if #(
    parameter int unsigned P_MAX_NUM_PERIODS = 100,
    parameter int unsigned P_MAX_WARMUP      = 255,
    parameter int unsigned P_NUM_CH          = 4
);
    localparam int unsigned PW = $clog2(P_MAX_NUM_PERIODS + 1);
    localparam int unsigned WW = $clog2(P_MAX_WARMUP + 1);

    logic                io_nc_start;
    logic                io_nc_abort;
    logic [PW-1:0]       io_nc_max_per;
    logic [WW-1:0]       io_nc_warmup_cnt;
    logic [P_NUM_CH-1:0] io_nc_ch_en;
    logic                io_nc_final_tx;
    logic [P_NUM_CH-1:0] api_nc_done;

    logic                nc_reset;
    logic                nc_warmup;
    logic                nc_evaluate;
    logic [P_NUM_CH-1:0] nc_transmit;
    logic [PW-1:0]       nc_io_cur_per;
    logic                nc_io_busy;
    logic                nc_io_done;
    logic                nc_io_aborted;

    modport master (
        output io_nc_start,
        output io_nc_abort,
        output io_nc_max_per,
        output io_nc_warmup_cnt,
        output io_nc_ch_en,
        output io_nc_final_tx,
        output api_nc_done,
        input  nc_reset,
        input  nc_warmup,
        input  nc_evaluate,
        input  nc_transmit,
        input  nc_io_cur_per,
        input  nc_io_busy,
        input  nc_io_done,
        input  nc_io_aborted
    );

    modport slave (
        input  io_nc_start,
        input  io_nc_abort,
        input  io_nc_max_per,
        input  io_nc_warmup_cnt,
        input  io_nc_ch_en,
        input  io_nc_final_tx,
        input  api_nc_done,
        output nc_reset,
        output nc_warmup,
        output nc_evaluate,
        output nc_transmit,
        output nc_io_cur_per,
        output nc_io_busy,
        output nc_io_done,
        output nc_io_aborted
    );
endinterface

// File: rtl/sn_net_ctrlr_mc.sv
// sn_net_ctrlr_mc -- execution sequencer for a spiking-neuron network.
//
// A software start launches an optional warmup (one evaluate per cycle), then
// a number of periods, each an evaluate cycle followed by a transmit phase in
// which every enabled API channel is asked to send until it reports done.
// The transmit phase after the final evaluation is optional. Abort returns to
// idle from any active state and is flagged until the next accepted start.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    sn_net_ctrlr_mc_if.slave, control inputs / strobes / status
//
// Parameters must match those of the connected interface instance.
`timescale 1ns / 1ps

module sn_net_ctrlr_mc #(
    parameter int unsigned P_MAX_NUM_PERIODS = 100,
    parameter int unsigned P_MAX_WARMUP      = 255,
    parameter int unsigned P_NUM_CH          = 4
) (
    input logic              clk,
    input logic              rst_n,
    sn_net_ctrlr_mc_if.slave bus
);

    localparam int unsigned PW = $clog2(P_MAX_NUM_PERIODS + 1);
    localparam int unsigned WW = $clog2(P_MAX_WARMUP + 1);

    localparam logic [PW-1:0] MaxPer = PW'(P_MAX_NUM_PERIODS);
    localparam logic [PW-1:0] PerOne = PW'(1);
    localparam logic [WW-1:0] WuOne  = WW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StEval,
        StTrans
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0]       cur_per_q, cur_per_d;
    logic [WW-1:0]       wu_cnt_q, wu_cnt_d;
    logic [P_NUM_CH-1:0] sent_q, sent_d;

    // Shadow copies of the run configuration, frozen at start acceptance.
    logic [PW-1:0]       max_per_q, max_per_d;
    logic [P_NUM_CH-1:0] ch_en_q, ch_en_d;
    logic                final_tx_q, final_tx_d;

    logic                aborted_q, aborted_d;

    logic                start_ok;
    logic                abort_hit;
    logic                last_per;
    logic [PW-1:0]       max_per_sat;
    logic [P_NUM_CH-1:0] done_en;
    logic                tx_all_sat;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    assign start_ok    = (state_q == StIdle) && bus.io_nc_start && (bus.io_nc_max_per != '0);
    assign abort_hit   = (state_q != StIdle) && bus.io_nc_abort;
    assign last_per    = (cur_per_q == max_per_q);
    assign max_per_sat = (bus.io_nc_max_per > MaxPer) ? MaxPer : bus.io_nc_max_per;

    // Done pulses only count for enabled channels; a channel already marked
    // sent is satisfied regardless of what it reports now.
    assign done_en     = bus.api_nc_done & ch_en_q;
    assign tx_all_sat  = ((sent_q | done_en) & ch_en_q) == ch_en_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_per_d  = cur_per_q;
        wu_cnt_d   = wu_cnt_q;
        sent_d     = sent_q;
        max_per_d  = max_per_q;
        ch_en_d    = ch_en_q;
        final_tx_d = final_tx_q;
        aborted_d  = aborted_q;

        if (abort_hit) begin
            // Abort wins over every other transition; cur_per is kept so
            // software can see how far the run got.
            state_d   = StIdle;
            aborted_d = 1'b1;
            wu_cnt_d  = '0;
            sent_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        max_per_d  = max_per_sat;
                        ch_en_d    = bus.io_nc_ch_en;
                        final_tx_d = bus.io_nc_final_tx;
                        aborted_d  = 1'b0;
                        sent_d     = '0;
                        if (bus.io_nc_warmup_cnt == '0) begin
                            state_d   = StEval;
                            cur_per_d = PerOne;
                            wu_cnt_d  = '0;
                        end else begin
                            state_d   = StWarmup;
                            cur_per_d = '0;
                            wu_cnt_d  = bus.io_nc_warmup_cnt;
                        end
                    end
                end

                StWarmup: begin
                    wu_cnt_d = wu_cnt_q - 1'b1;
                    if (wu_cnt_q == WuOne) begin
                        state_d   = StEval;
                        cur_per_d = PerOne;
                    end
                end

                StEval: begin
                    if (last_per && !final_tx_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StTrans;
                    end
                end

                StTrans: begin
                    if (tx_all_sat) begin
                        sent_d = '0;
                        if (last_per) begin
                            state_d = StIdle;
                        end else begin
                            state_d   = StEval;
                            cur_per_d = cur_per_q + 1'b1;
                        end
                    end else begin
                        sent_d = sent_q | done_en;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_per_q  <= '0;
            wu_cnt_q   <= '0;
            sent_q     <= '0;
            max_per_q  <= '0;
            ch_en_q    <= '0;
            final_tx_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_per_q  <= cur_per_d;
            wu_cnt_q   <= wu_cnt_d;
            sent_q     <= sent_d;
            max_per_q  <= max_per_d;
            ch_en_q    <= ch_en_d;
            final_tx_q <= final_tx_d;
            aborted_q  <= aborted_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes decode straight from the state register so an
    // asynchronous reset removes them without waiting for a clock.
    // ------------------------------------------------------------------
    assign bus.nc_reset      = start_ok;
    assign bus.nc_warmup     = (state_q == StWarmup);
    assign bus.nc_evaluate   = (state_q == StWarmup) || (state_q == StEval);
    assign bus.nc_transmit   = (state_q == StTrans) ? (ch_en_q & ~sent_q) : '0;
    assign bus.nc_io_cur_per = cur_per_q;
    assign bus.nc_io_busy    = (state_q != StIdle);
    assign bus.nc_io_done    = (state_q == StIdle);
    assign bus.nc_io_aborted = aborted_q;

endmodule

// File: tb/tb_sn_net_ctrlr_mc.sv
`timescale 1ns / 1ps

module tb_sn_net_ctrlr_mc;

    localparam int unsigned MAXP = 100;
    localparam int unsigned MAXW = 255;
    localparam int unsigned NCH  = 4;
    localparam int unsigned PW   = $clog2(MAXP + 1);
    localparam int unsigned WW   = $clog2(MAXW + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sn_net_ctrlr_mc_if #(
        .P_MAX_NUM_PERIODS(MAXP),
        .P_MAX_WARMUP     (MAXW),
        .P_NUM_CH         (NCH)
    ) bus ();

    sn_net_ctrlr_mc #(
        .P_MAX_NUM_PERIODS(MAXP),
        .P_MAX_WARMUP     (MAXW),
        .P_NUM_CH         (NCH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: run-level bookkeeping of what software asked for.
    // Updated at each falling edge with the inputs the next rising edge
    // will see, so it always describes the upcoming cycle.
    // ------------------------------------------------------------------
    bit       m_busy;
    bit       m_in_tx;
    bit       m_final;
    bit       m_aborted;
    int       m_warm_left;
    int       m_per;
    int       m_maxp;
    bit [3:0] m_chen;
    bit [3:0] m_owed;

    always @(negedge clk) begin
        int       mp;
        bit       exp_reset;
        bit [3:0] exp_tx;

        if (!rst_n) begin
            m_busy      = 0;
            m_in_tx     = 0;
            m_final     = 0;
            m_aborted   = 0;
            m_warm_left = 0;
            m_per       = 0;
            m_maxp      = 0;
            m_chen      = '0;
            m_owed      = '0;
        end

        mp        = int'(bus.io_nc_max_per);
        exp_reset = rst_n && !m_busy && bus.io_nc_start && (mp != 0);
        exp_tx    = (m_busy && m_in_tx) ? m_owed : 4'b0000;

        cmp("mdl_reset",   bus.nc_reset,      exp_reset);
        cmp("mdl_warmup",  bus.nc_warmup,     m_busy && m_warm_left > 0);
        cmp("mdl_eval",    bus.nc_evaluate,   m_busy && !m_in_tx);
        cmp("mdl_tx",      bus.nc_transmit,   exp_tx);
        cmp("mdl_cur_per", bus.nc_io_cur_per, m_per);
        cmp("mdl_busy",    bus.nc_io_busy,    m_busy);
        cmp("mdl_done",    bus.nc_io_done,    !m_busy);
        cmp("mdl_aborted", bus.nc_io_aborted, m_aborted);

        if (rst_n) begin
            if (!m_busy) begin
                if (exp_reset) begin
                    m_busy      = 1;
                    m_aborted   = 0;
                    m_in_tx     = 0;
                    m_maxp      = (mp > MAXP) ? MAXP : mp;
                    m_chen      = bus.io_nc_ch_en;
                    m_final     = bus.io_nc_final_tx;
                    m_warm_left = int'(bus.io_nc_warmup_cnt);
                    m_per       = (m_warm_left == 0) ? 1 : 0;
                end
            end else if (bus.io_nc_abort) begin
                m_busy      = 0;
                m_aborted   = 1;
                m_in_tx     = 0;
                m_warm_left = 0;
            end else if (m_warm_left > 0) begin
                m_warm_left--;
                if (m_warm_left == 0) m_per = 1;
            end else if (!m_in_tx) begin
                if (m_per == m_maxp && !m_final) begin
                    m_busy = 0;
                end else begin
                    m_in_tx = 1;
                    m_owed  = m_chen;
                end
            end else begin
                m_owed = m_owed & ~bus.api_nc_done;
                if (m_owed == 4'b0000) begin
                    m_in_tx = 0;
                    if (m_per == m_maxp) m_busy = 0;
                    else m_per++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int mp, input int wu, input logic [3:0] ce, input bit ft);
        step();
        bus.io_nc_start      = 1'b1;
        bus.io_nc_max_per    = PW'(mp);
        bus.io_nc_warmup_cnt = WW'(wu);
        bus.io_nc_ch_en      = ce;
        bus.io_nc_final_tx   = ft;
    endtask

    task automatic drain(input string tag, input int budget);
        bus.io_nc_start = 1'b0;
        bus.io_nc_abort = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.nc_io_busy) break;
            step();
            bus.api_nc_done = 4'($urandom);
        end
        cmp(tag, bus.nc_io_busy, 1'b0);
        bus.api_nc_done = '0;
    endtask

    // {warmup, evaluate, transmit[0]} per cycle after acceptance
    int t1_exp[9] = '{6, 6, 6, 2, 1, 1, 1, 2, 0};
    // {warmup, evaluate, |transmit, busy} per cycle after acceptance
    int t5_exp[6] = '{5, 1, 5, 1, 5, 0};

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.io_nc_start      = 1'b0;
        bus.io_nc_abort      = 1'b0;
        bus.io_nc_max_per    = '0;
        bus.io_nc_warmup_cnt = '0;
        bus.io_nc_ch_en      = '0;
        bus.io_nc_final_tx   = 1'b0;
        bus.api_nc_done      = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("rst_done",    bus.nc_io_done,    1'b1);
        cmp("rst_busy",    bus.nc_io_busy,    1'b0);
        cmp("rst_cur_per", bus.nc_io_cur_per, 0);
        cmp("rst_aborted", bus.nc_io_aborted, 1'b0);

        // Three warmups, two periods, ch0 answers two cycles after request.
        go(2, 3, 4'b0001, 1'b0);
        @(negedge clk);
        cmp("t1_reset", bus.nc_reset, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step();
            bus.io_nc_start = 1'b0;
            bus.api_nc_done = (k == 6) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            cmp($sformatf("t1_cyc%0d", k),
                {bus.nc_warmup, bus.nc_evaluate, bus.nc_transmit[0]}, t1_exp[k]);
            if (k == 3) cmp("t1_per1", bus.nc_io_cur_per, 1);
        end
        cmp("t1_cur_per", bus.nc_io_cur_per, 2);
        cmp("t1_done",    bus.nc_io_done,    1'b1);
        bus.api_nc_done = '0;

        // One period with final transmit; channels finish 3, 0, 1.
        go(1, 0, 4'b1011, 1'b1);
        @(negedge clk);
        cmp("t2_reset", bus.nc_reset, 1'b1);
        step();
        bus.io_nc_start = 1'b0;
        @(negedge clk);
        cmp("t2_eval", bus.nc_evaluate, 1'b1);
        step();
        bus.api_nc_done = 4'b1000;
        @(negedge clk);
        cmp("t2_tx_a", bus.nc_transmit, 4'b1011);
        step();
        bus.api_nc_done = 4'b0001;
        @(negedge clk);
        cmp("t2_tx_b", bus.nc_transmit, 4'b0011);
        step();
        bus.api_nc_done = 4'b0010;
        @(negedge clk);
        cmp("t2_tx_c", bus.nc_transmit, 4'b0010);
        step();
        bus.api_nc_done = 4'b0000;
        @(negedge clk);
        cmp("t2_tx_off",  bus.nc_transmit,   4'b0000);
        cmp("t2_busy",    bus.nc_io_busy,    1'b0);
        cmp("t2_cur_per", bus.nc_io_cur_per, 1);

        // Abort while period 5 is still transmitting.
        go(7, 0, 4'b0001, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            bus.io_nc_start = 1'b0;
            bus.api_nc_done = (k % 2 == 1 && k < 9) ? 4'b0001 : 4'b0000;
        end
        step();
        bus.api_nc_done = 4'b0000;
        bus.io_nc_abort = 1'b1;
        @(negedge clk);
        cmp("t3_tx_before", bus.nc_transmit,   4'b0001);
        cmp("t3_per5",      bus.nc_io_cur_per, 5);
        step();
        bus.io_nc_abort = 1'b0;
        @(negedge clk);
        cmp("t3_busy",    bus.nc_io_busy,    1'b0);
        cmp("t3_aborted", bus.nc_io_aborted, 1'b1);
        cmp("t3_cur_per", bus.nc_io_cur_per, 5);
        cmp("t3_tx_off",  bus.nc_transmit,   4'b0000);
        go(2, 0, 4'b0001, 1'b0);
        step();
        bus.io_nc_start = 1'b0;
        @(negedge clk);
        cmp("t3_abort_clr", bus.nc_io_aborted, 1'b0);
        cmp("t3_restart",   bus.nc_io_cur_per, 1);
        drain("t3_drain", 400);

        // Zero-period start ignored; start+abort in idle accepted;
        // start while busy ignored and shadows hold.
        go(0, 2, 4'hF, 1'b0);
        @(negedge clk);
        cmp("t4_zero_reset", bus.nc_reset, 1'b0);
        step();
        bus.io_nc_start = 1'b0;
        @(negedge clk);
        cmp("t4_zero_busy", bus.nc_io_busy, 1'b0);
        go(3, 2, 4'b0101, 1'b0);
        bus.io_nc_abort = 1'b1;
        @(negedge clk);
        cmp("t4_sa_reset", bus.nc_reset, 1'b1);
        step();
        bus.io_nc_start = 1'b0;
        bus.io_nc_abort = 1'b0;
        @(negedge clk);
        cmp("t4_sa_busy",   bus.nc_io_busy, 1'b1);
        cmp("t4_sa_warmup", bus.nc_warmup,  1'b1);
        go(1, 0, 4'b0000, 1'b0);
        @(negedge clk);
        cmp("t4_busy_reset", bus.nc_reset,  1'b0);
        cmp("t4_busy_warm",  bus.nc_warmup, 1'b1);
        step();
        bus.io_nc_start = 1'b0;
        @(negedge clk);
        cmp("t4_eval", {bus.nc_warmup, bus.nc_evaluate}, 2'b01);
        drain("t4_drain", 400);
        cmp("t4_cur_per", bus.nc_io_cur_per, 3);

        // No channels enabled: E,T,E,T,E, done pulses ignored.
        go(3, 0, 4'b0000, 1'b0);
        bus.api_nc_done = 4'hF;
        for (int k = 0; k < 6; k++) begin
            step();
            bus.io_nc_start = 1'b0;
            @(negedge clk);
            cmp($sformatf("t5_cyc%0d", k),
                {bus.nc_warmup, bus.nc_evaluate, |bus.nc_transmit, bus.nc_io_busy}, t5_exp[k]);
        end
        bus.api_nc_done = '0;

        // Asynchronous reset in the middle of an evaluate cycle.
        go(2, 0, 4'b0011, 1'b0);
        step();
        bus.io_nc_start = 1'b0;
        cmp("t6_in_eval", bus.nc_evaluate, 1'b1);
        rst_n = 1'b0;
        #1;
        cmp("t6_eval_off", bus.nc_evaluate,   1'b0);
        cmp("t6_done",     bus.nc_io_done,    1'b1);
        cmp("t6_cur_per",  bus.nc_io_cur_per, 0);
        cmp("t6_tx_off",   bus.nc_transmit,   4'b0000);
        step();
        rst_n = 1'b1;

        // Period count above the limit saturates.
        go(MAXP + 5, 1, 4'($urandom), 1'b0);
        step();
        bus.io_nc_start = 1'b0;
        drain("t6_sat_drain", 3000);
        cmp("t6_sat_cur_per", bus.nc_io_cur_per, MAXP);

        // Random traffic: every input re-rolled every cycle.
        for (int c = 0; c < 2500; c++) begin
            step();
            bus.io_nc_start      = ($urandom_range(0, 5) == 0);
            bus.io_nc_abort      = ($urandom_range(0, 39) == 0);
            bus.io_nc_max_per    = ($urandom_range(0, 49) == 0) ? PW'(127)
                                                                : PW'($urandom_range(0, 5));
            bus.io_nc_warmup_cnt = WW'($urandom_range(0, 3));
            bus.io_nc_ch_en      = 4'($urandom);
            bus.io_nc_final_tx   = 1'($urandom);
            bus.api_nc_done      = 4'($urandom);
        end
        drain("rand_drain", 3000);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
